// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide unit with valid/ready issue and result handshakes.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and special-case divides finish early.
module muldiv_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] opA,
   input  logic [DATA_WIDTH-1:0] opB,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  div_by_zero,
   output logic                  div_overflow
);

   localparam int unsigned W = DATA_WIDTH;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2*W-1:0]     acc_q, acc_d;
   logic [W-1:0]       opnd_q, opnd_d;
   logic [2:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic               sa_q, sa_d;
   logic               dbz_q, dbz_d;
   logic               ovf_q, ovf_d;
   logic [W-1:0]       result_q, result_d;
   logic               dbz_out_q, dbz_out_d;
   logic               ovf_out_q, ovf_out_d;

   // Operand decode at issue time
   logic         a_signed, b_signed, sa, sb, dbz_in, ovf_in;
   logic [W-1:0] abs_a, abs_b;

   assign a_signed = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
   assign b_signed = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
   assign sa       = a_signed & opA[W-1];
   assign sb       = b_signed & opB[W-1];
   assign abs_a    = sa ? (~opA + 1'b1) : opA;
   assign abs_b    = sb ? (~opB + 1'b1) : opB;
   assign dbz_in   = op[2] & (opB == '0);
   assign ovf_in   = op[2] & ~op[0] & (opA == {1'b1, {(W-1){1'b0}}}) & (opB == '1);

`ifdef MULDIV_EARLY_OUT_EN
   logic early_in;
   assign early_in = (~op[2] & ((opA == '0) | (opB == '0))) | dbz_in | ovf_in;
`endif

   // One iteration step; acc holds {hi, lo} = {partial product, multiplier} or {rem, quotient}
   logic [W:0]     mul_sum, div_shift, div_diff;
   logic [2*W-1:0] mul_next, div_next;

   assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next  = {mul_sum, acc_q[W-1:1]};
   assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

   // Sign fix and result selection
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix, rem_fix, final_res;

   assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
   assign quo_fix  = dbz_q ? '1 : (neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0]);
   assign rem_fix  = sa_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

   always_comb begin
      final_res = '0;
      unique case (op_q)
         3'b000:                 final_res = prod_fix[W-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_fix[2*W-1:W];
         3'b100, 3'b101:         final_res = quo_fix;
         default:                final_res = rem_fix;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      op_d      = op_q;
      neg_d     = neg_q;
      sa_d      = sa_q;
      dbz_d     = dbz_q;
      ovf_d     = ovf_q;
      result_d  = result_q;
      dbz_out_d = dbz_out_q;
      ovf_out_d = ovf_out_q;

      if (flush) begin
         state_d   = StIdle;
         cnt_d     = '0;
         dbz_out_d = 1'b0;
         ovf_out_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  state_d = StCalc;
                  cnt_d   = CNT_WIDTH'(W);
                  op_d    = op;
                  neg_d   = sa ^ sb;
                  sa_d    = sa;
                  dbz_d   = dbz_in;
                  ovf_d   = ovf_in;
                  opnd_d  = op[2] ? abs_b : abs_a;
                  acc_d   = {{W{1'b0}}, (op[2] ? abs_a : abs_b)};
`ifdef MULDIV_EARLY_OUT_EN
                  // Zero count: the next edge goes straight to DONE with a preloaded accumulator
                  if (early_in) begin
                     cnt_d = '0;
                     if (dbz_in) acc_d = {abs_a, {W{1'b1}}};
                     else if (!op[2]) acc_d = '0;
                  end
`endif
               end
            end
            StCalc: begin
               if (cnt_q == '0) begin
                  state_d   = StDone;
                  result_d  = final_res;
                  dbz_out_d = dbz_q;
                  ovf_out_d = ovf_q;
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  acc_d = op_q[2] ? div_next : mul_next;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_d   = StIdle;
                  dbz_out_d = 1'b0;
                  ovf_out_d = 1'b0;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         sa_q      <= 1'b0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
         result_q  <= '0;
         dbz_out_q <= 1'b0;
         ovf_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         sa_q      <= sa_d;
         dbz_q     <= dbz_d;
         ovf_q     <= ovf_d;
         result_q  <= result_d;
         dbz_out_q <= dbz_out_d;
         ovf_out_q <= ovf_out_d;
      end
   end

   assign in_ready     = (state_q == StIdle);
   assign out_valid    = (state_q == StDone);
   assign result       = result_q;
   assign div_by_zero  = dbz_out_q;
   assign div_overflow = ovf_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at W=32: vector table, random ops against a 64-bit model,
// handshake hold, flush and asynchronous reset sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = '0;
   logic [31:0] opA = '0;
   logic [31:0] opB = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        div_by_zero;
   logic        div_overflow;

   int tests = 0;
   int fails = 0;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op           (op),
      .opA          (opA),
      .opB          (opB),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .div_by_zero  (div_by_zero),
      .div_overflow (div_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        dbz;
      logic        ovf;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic        dbz;
      logic        ovf;
      int          lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb64, sub;
      logic [63:0] ua, ub, p;
      logic ovf;
      sa   = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      ua   = {32'b0, a};
      ub   = {32'b0, b};
      sub  = ub;
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p    = '0;
      case (o)
         3'd0: begin p = sa * sb64; return p[31:0]; end
         3'd1: begin p = sa * sb64; return p[63:32]; end
         3'd2: begin p = sa * sub;  return p[63:32]; end
         3'd3: begin p = ua * ub;   return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = sa / sb64; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            p = sa % sb64; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic early;
      early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      early = (!o[2] && (a == 0 || b == 0)) || (o[2] && b == 0) ||
              (o[2] && !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`endif
      return early ? 1 : 33;
   endfunction

   // Issue one op, wait for its result, compare against the scoreboard head, then release it.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic dbz, input logic ovf,
                         input int hold);
      exp_t e;
      int   n;
      e.res = res; e.dbz = dbz; e.ovf = ovf; e.lat = latency(o, a, b);
      @(negedge clk);
      check("issue_in_ready", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1; op = o; opA = a; opB = b;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1 n++;
         if (n == 1 && !out_valid) check("busy_in_ready", {31'b0, in_ready}, 32'd0);
         if (out_valid) break;
      end
      e = sb.pop_front();
      if (!out_valid) begin
         tests++; fails++;
         $display("FAIL timeout op=%0d a=%h b=%h: no out_valid after %0d edges", o, a, b, n);
         @(negedge clk) flush = 1'b1;
         @(negedge clk) flush = 1'b0;
         return;
      end
      check("latency", n, e.lat);
      check("result", result, e.res);
      check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
      check("div_overflow", {31'b0, div_overflow}, {31'b0, e.ovf});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", {31'b0, out_valid}, 32'd1);
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("hold_result", result, e.res);
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("release_in_ready", {31'b0, in_ready}, 32'd1);
      check("release_valid", {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0};
      vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0};
      vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0};
      vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1'b1, 1'b0};
      vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
      vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1};
      vecs[12] = '{3'd0, 32'd0,         32'd5,         32'd0,         1'b0, 1'b0};
      vecs[13] = '{3'd6, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 1'b1, 1'b0};
      vecs[14] = '{3'd4, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[15] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0};
      vecs[16] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 1'b0};
      vecs[17] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[18] = '{3'd0, 32'h1234_5678, 32'h10,        32'h2345_6780, 1'b0, 1'b0};
      vecs[19] = '{3'd7, 32'd7,         32'd0,         32'd7,         1'b1, 1'b0};

      #12;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {30'b0, div_by_zero, div_overflow}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 20; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz, vecs[i].ovf, 0);

      for (int i = 0; i < 24; i++) begin
         logic [2:0]  o;
         logic [31:0] a, b;
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         run_op(o, a, b, model(o, a, b), o[2] && b == 0,
                o[2] && !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF, 0);
      end

      // Result held in DONE while the consumer stalls
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 5);

      // Flush mid-CALC with a competing issue request in the same cycle
      begin
         int seen;
         @(negedge clk);
         in_valid = 1'b1; op = 3'd0; opA = 32'd3; opB = 32'd4;
         @(posedge clk);
         #1 in_valid = 1'b0;
         repeat (10) @(posedge clk);
         @(negedge clk);
         flush = 1'b1; in_valid = 1'b1; op = 3'd5; opA = 32'd50; opB = 32'd5;
         @(posedge clk);
         #1 flush = 1'b0; in_valid = 1'b0;
         check("flush_in_ready", {31'b0, in_ready}, 32'd1);
         check("flush_out_valid", {31'b0, out_valid}, 32'd0);
         seen = 0;
         repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
         end
         check("flush_no_output", seen, 0);
         run_op(3'd5, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0, 0);
      end

      // Asynchronous reset in the middle of a calculation
      @(negedge clk);
      in_valid = 1'b1; op = 3'd4; opA = 32'd1000; opB = 32'd7;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_in_ready", {31'b0, in_ready}, 32'd1);
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_result", result, 32'd0);
      check("arst_flags", {30'b0, div_by_zero, div_overflow}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
